multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. Sequences instruction fetch, decode, execute, memory and writeback over several clocks.
- Drives the datapath mux selects and the write enables for the PC, IR, register file and memory.
- Produces the 2-bit ALU operation class consumed by the ALU control decoder: 00 = add, 01 = subtract/branch, 10 = R-type funct.
- Waits on a memory-ready handshake in every memory-access state and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter; wraps at 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26]; sampled in DECODE only
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
- alu_op  output  2  ALU operation class to the ALU control decoder
- pc_source  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding, for debug
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- retired_cnt  output  CNT_W  completed instructions

Behaviour:
- Moore FSM. One 4-bit state register, asynchronous clear to FETCH. All control outputs are combinational from state, plus mem_ready where noted. Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 go to FETCH on the next edge with all outputs 0.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00.
  - ir_write = pc_write = mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDI_EX; 000010 -> JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 for exactly the next cycle (registered pulse).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_READ if opcode was lw, else MEM_WRITE. The opcode is latched in DECODE; the opcode input is not re-sampled.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH (retires).
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH (retires).
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH (retires).
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH (retires).
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH (retires).
- JUMP: pc_write=1, pc_source=10. Then FETCH (retires).
- retired_cnt:
  - Increments by 1 on every transition into FETCH from MEM_WRITE, MEM_WB, ALU_WB, BRANCH, ADDI_WB or JUMP.
  - Illegal-opcode returns do not count.
  - Wraps to 0 after all-ones.
- Reset values: state=0 (FETCH), retired_cnt=0, illegal_op=0. Outputs then reflect FETCH: mem_read=1, alu_src_b=01, ir_write = pc_write = mem_ready, all others 0.
- Reset asserted mid-instruction, including during a memory wait, aborts immediately to FETCH. No write strobe may remain asserted after rst_n falls.
- mem_ready is ignored in states that do not access memory.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_JUMP_EN.
- Defined: JUMP state present; opcode 000010 -> JUMP as described above.
- Undefined: JUMP state and pc_source=10 are never generated; opcode 000010 is illegal (-> FETCH, illegal_op pulse, not retired).

Test Plan:
- Reset mid-MEM_READ with mem_ready=0 -> state=0, mem_write=0, reg_write=0, retired_cnt=0 while rst_n=0.
- R-type, opcode 000000, mem_ready=1 every cycle -> states 0,1,6,7,0; alu_op=10 in EXECUTE; reg_write=1, reg_dst=1 in ALU_WB; retired_cnt 0 -> 1.
- lw with mem_ready low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; mem_read=1, i_or_d=1 throughout the waits; reg_write=1, mem_to_reg=1 in MEM_WB.
- beq (000100) then sw (101011) -> BRANCH with alu_op=01, pc_write_cond=1, pc_source=01; sw path 0,1,2,5,0; retired_cnt=2.
- Opcode 111111 -> states 0,1,0; illegal_op=1 for exactly 1 cycle; retired_cnt unchanged.
- With the macro, j (000010) -> JUMP with pc_write=1, pc_source=10. Without the macro -> illegal_op pulse. Force retired_cnt to all-ones with CNT_W=4 -> wraps to 0 on the next retire.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Define MULTICYCLE_CONTROL_JUMP_EN to enable the JUMP state (opcode 000010); otherwise j is illegal.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur_state, next_state;
  logic [5:0] opcode_q;
  logic       illegal_d;
  logic       retire;

  assign state = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= FETCH;
      opcode_q    <= '0;
      illegal_op  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      cur_state  <= next_state;
      illegal_op <= illegal_d;
      // MEM_ADDR steers on this copy so the IR input need not stay stable past DECODE
      if (cur_state == DECODE)
        opcode_q <= opcode;
      if (retire)
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state    = FETCH;
    illegal_d     = 1'b0;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (cur_state)
      FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDI_EX;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_J:         next_state = JUMP;
`endif
          default: begin
            next_state = FETCH;
            illegal_d  = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode_q == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? FETCH : MEM_WRITE;
        retire     = mem_ready;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
`endif
      default: next_state = FETCH;
    endcase
  end

endmodule
